pc_fetch_ctrl: RTL and testbench

//  Fetch-stage sequencer for the PC register. Drives pc_write/pc_next and runs the

---
 rtl/pc_fetch_ctrl_if.sv | 28 ++
 rtl/pc_fetch_ctrl.sv | 109 ++++++++++
 tb/tb_pc_fetch_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// PC register / instruction-memory handshake bundle for the fetch sequencer.
// master = fetch controller, slave = PC register + imem side.
interface pc_fetch_ctrl_if;
    logic [31:0] pc_cur;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        imem_req;
    logic        imem_ready;
    logic        fetch_valid;

    modport master (
        input  pc_cur,
        input  imem_ready,
        output pc_write,
        output pc_next,
        output imem_req,
        output fetch_valid
    );

    modport slave (
        output pc_cur,
        output imem_ready,
        input  pc_write,
        input  pc_next,
        input  imem_req,
        input  fetch_valid
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: redirect > stall > +4, with redirects held across imem waits.
// Optional macro PC_MISALIGN_TRAP_EN sends misaligned targets to TRAP_VECTOR.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic                   clk,
    input  logic                   rst,
    pc_fetch_ctrl_if.master        bus,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_target,
    output logic                   flush_if_id,
    output logic                   trap_misalign
);

    typedef enum logic [1:0] {BOOT, FETCH, WAIT} state_t;

    state_t      state_q, state_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        load_en;
    logic [31:0] load_tgt;

    always_comb begin
        state_d           = state_q;
        pend_vld_d        = pend_vld_q;
        pend_tgt_d        = pend_tgt_q;
        load_en           = 1'b0;
        load_tgt          = redirect_target;
        bus.pc_write      = 1'b0;
        bus.pc_next       = bus.pc_cur;
        bus.imem_req      = 1'b0;
        bus.fetch_valid   = 1'b0;
        flush_if_id       = 1'b0;
        trap_misalign     = 1'b0;

        case (state_q)
            BOOT: begin
                bus.pc_write = 1'b1;
                bus.pc_next  = RESET_VECTOR;
                state_d      = FETCH;
            end
            FETCH, WAIT: begin
                bus.imem_req = 1'b1;
                if (!bus.imem_ready) begin
                    // Newest redirect seen while the fetch is outstanding wins.
                    if (redirect) begin
                        pend_tgt_d = redirect_target;
                        pend_vld_d = 1'b1;
                    end
                    state_d = WAIT;
                end else begin
                    state_d    = FETCH;
                    pend_vld_d = 1'b0;
                    if (redirect) begin
                        load_en = 1'b1;
                    end else if (state_q == WAIT && pend_vld_q) begin
                        load_en  = 1'b1;
                        load_tgt = pend_tgt_q;
                    end else if (!stall) begin
                        bus.pc_write    = 1'b1;
                        bus.pc_next     = bus.pc_cur + 32'd4;
                        bus.fetch_valid = 1'b1;
                    end
                end
            end
            default: state_d = BOOT;
        endcase

        if (load_en) begin
            bus.pc_write = 1'b1;
            flush_if_id  = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            if (load_tgt[1:0] != 2'b00) begin
                bus.pc_next   = TRAP_VECTOR;
                trap_misalign = 1'b1;
            end else begin
                bus.pc_next = load_tgt;
            end
`else
            bus.pc_next = {load_tgt[31:2], 2'b00};
`endif
        end

        // Outputs follow reset immediately, not just at the next edge.
        if (!rst) begin
            bus.pc_write    = 1'b0;
            bus.pc_next     = RESET_VECTOR;
            bus.imem_req    = 1'b0;
            bus.fetch_valid = 1'b0;
            flush_if_id     = 1'b0;
            trap_misalign   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, reset-in-WAIT sequence,
// then randomized traffic against a queue-based reference model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        flush_if_id;
    logic        trap_misalign;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(
        .RESET_VECTOR (RESET_VECTOR),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .flush_if_id     (flush_if_id),
        .trap_misalign   (trap_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          stall;
        bit          redirect;
        logic [31:0] tgt;
        bit          ready;
        bit          exp_write;
        logic [31:0] exp_next;
        bit          exp_req;
        bit          exp_fv;
        bit          exp_flush;
        bit          exp_trap;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: boot pending, fetch outstanding, redirects seen while outstanding.
    bit          m_booted;
    bit          m_waiting;
    logic [31:0] m_pend[$];

    function automatic vec_t mk(input logic [31:0] pc, input bit st, input bit rd,
                                input logic [31:0] tgt, input bit rdy, input bit w,
                                input logic [31:0] nxt, input bit req, input bit fv,
                                input bit fl, input bit tr);
        vec_t v;
        v.pc = pc; v.stall = st; v.redirect = rd; v.tgt = tgt; v.ready = rdy;
        v.exp_write = w; v.exp_next = nxt; v.exp_req = req; v.exp_fv = fv;
        v.exp_flush = fl; v.exp_trap = tr;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        @(negedge clk);
        bus.pc_cur      = v.pc;
        bus.imem_ready  = v.ready;
        stall           = v.stall;
        redirect        = v.redirect;
        redirect_target = v.tgt;
        #1;
        check_output({tag, " pc_write"},    {31'b0, bus.pc_write},    {31'b0, v.exp_write});
        if (v.exp_write)
            check_output({tag, " pc_next"}, bus.pc_next, v.exp_next);
        check_output({tag, " imem_req"},    {31'b0, bus.imem_req},    {31'b0, v.exp_req});
        check_output({tag, " fetch_valid"}, {31'b0, bus.fetch_valid}, {31'b0, v.exp_fv});
        check_output({tag, " flush_if_id"}, {31'b0, flush_if_id},     {31'b0, v.exp_flush});
        check_output({tag, " trap"},        {31'b0, trap_misalign},   {31'b0, v.exp_trap});
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, " rst pc_write"},    {31'b0, bus.pc_write},    32'd0);
        check_output({tag, " rst pc_next"},     bus.pc_next,              RESET_VECTOR);
        check_output({tag, " rst imem_req"},    {31'b0, bus.imem_req},    32'd0);
        check_output({tag, " rst fetch_valid"}, {31'b0, bus.fetch_valid}, 32'd0);
        check_output({tag, " rst flush"},       {31'b0, flush_if_id},     32'd0);
        check_output({tag, " rst trap"},        {31'b0, trap_misalign},   32'd0);
    endtask

    // Reset asserted mid-cycle, checked before any clock edge, released just after a rising edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset(tag);
        @(posedge clk);
        #1 rst = 1'b1;
        m_booted  = 1'b0;
        m_waiting = 1'b0;
        m_pend.delete();
    endtask

    function automatic void land(input logic [31:0] t, output logic [31:0] nxt, output bit tr);
        if (t[1:0] == 2'b00) begin
            nxt = t;
            tr  = 1'b0;
        end else if (TRAP_ON) begin
            nxt = TRAP_VECTOR;
            tr  = 1'b1;
        end else begin
            nxt = t & 32'hFFFF_FFFC;
            tr  = 1'b0;
        end
    endfunction

    function automatic vec_t model_expect(input vec_t s);
        vec_t        e;
        bit          have;
        logic [31:0] t;
        e = s;
        e.exp_write = 1'b0; e.exp_next = 32'h0; e.exp_req = 1'b0;
        e.exp_fv = 1'b0; e.exp_flush = 1'b0; e.exp_trap = 1'b0;
        have = 1'b0;
        t    = 32'h0;
        if (!m_booted) begin
            e.exp_write = 1'b1;
            e.exp_next  = RESET_VECTOR;
        end else begin
            e.exp_req = 1'b1;
            if (s.ready) begin
                if (s.redirect) begin
                    have = 1'b1; t = s.tgt;
                end else if (m_waiting && m_pend.size() > 0) begin
                    have = 1'b1; t = m_pend[$];
                end
                if (have) begin
                    e.exp_write = 1'b1;
                    e.exp_flush = 1'b1;
                    land(t, e.exp_next, e.exp_trap);
                end else if (!s.stall) begin
                    e.exp_write = 1'b1;
                    e.exp_next  = s.pc + 32'd4;
                    e.exp_fv    = 1'b1;
                end
            end
        end
        return e;
    endfunction

    function automatic void model_commit(input vec_t s);
        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (!s.ready) begin
            if (s.redirect) m_pend.push_back(s.tgt);
            m_waiting = 1'b1;
        end else begin
            m_waiting = 1'b0;
            m_pend.delete();
        end
    endfunction

    vec_t tbl[15];

    initial begin
        logic [31:0] mis_next;
        logic [31:0] pc;
        vec_t        s;
        vec_t        e;

        mis_next = TRAP_ON ? TRAP_VECTOR : 32'h0000_0040;
        //             pc           st rd tgt           rdy w  next            req fv fl tr
        tbl[0]  = mk(32'h0,        0, 0, 32'h0,        1, 1, 32'h0,           0, 0, 0, 0);
        tbl[1]  = mk(32'h0,        0, 0, 32'h0,        1, 1, 32'h4,           1, 1, 0, 0);
        tbl[2]  = mk(32'h4,        0, 0, 32'h0,        1, 1, 32'h8,           1, 1, 0, 0);
        tbl[3]  = mk(32'h8,        1, 0, 32'h0,        1, 0, 32'h0,           1, 0, 0, 0);
        tbl[4]  = mk(32'h8,        1, 0, 32'h0,        1, 0, 32'h0,           1, 0, 0, 0);
        tbl[5]  = mk(32'h8,        0, 0, 32'h0,        1, 1, 32'hC,           1, 1, 0, 0);
        tbl[6]  = mk(32'hC,        0, 0, 32'h0,        1, 1, 32'h10,          1, 1, 0, 0);
        tbl[7]  = mk(32'h10,       0, 0, 32'h0,        0, 0, 32'h0,           1, 0, 0, 0);
        tbl[8]  = mk(32'h10,       0, 1, 32'h40,       0, 0, 32'h0,           1, 0, 0, 0);
        tbl[9]  = mk(32'h10,       0, 0, 32'h0,        0, 0, 32'h0,           1, 0, 0, 0);
        tbl[10] = mk(32'h10,       0, 0, 32'h0,        1, 1, 32'h40,          1, 0, 1, 0);
        tbl[11] = mk(32'h40,       1, 1, 32'h100,      1, 1, 32'h100,         1, 0, 1, 0);
        tbl[12] = mk(32'h100,      0, 1, 32'h42,       1, 1, mis_next,        1, 0, 1, TRAP_ON);
        tbl[13] = mk(mis_next,     0, 0, 32'h0,        1, 1, mis_next + 32'd4, 1, 1, 0, 0);
        tbl[14] = mk(32'hFFFF_FFFC, 0, 0, 32'h0,       1, 1, 32'h0,           1, 1, 0, 0);

        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        bus.pc_cur = 32'h0; bus.imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset("initial");
        rst = 1'b1;

        for (int i = 0; i < 15; i++)
            apply_stimulus(tbl[i], $sformatf("vec%0d", i));

        // Reset while a redirect is pending in WAIT must leave no trace of it.
        apply_stimulus(mk(32'h20, 0, 1, 32'h80, 0, 0, 32'h0, 1, 0, 0, 0), "r6 enter");
        do_reset("r6");
        apply_stimulus(mk(32'h20, 0, 0, 32'h0, 1, 1, RESET_VECTOR, 0, 0, 0, 0), "r6 boot");
        apply_stimulus(mk(32'h0,  0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0),        "r6 wait");
        apply_stimulus(mk(32'h0,  0, 0, 32'h0, 1, 1, 32'h4, 1, 1, 0, 0),        "r6 done");

        do_reset("rand start");
        pc = 32'h0;
        for (int c = 0; c < 400; c++) begin
            if (m_booted && !m_waiting && $urandom_range(0, 49) == 0)
                pc = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
            s.pc       = pc;
            s.stall    = ($urandom_range(0, 3) == 0);
            s.redirect = ($urandom_range(0, 4) == 0);
            s.tgt      = {$urandom_range(0, 65535), 14'h0, 2'b00}
                         | {30'h0, 2'($urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0)}
                         | {16'h0, 14'($urandom), 2'b00};
            s.ready    = ($urandom_range(0, 2) != 0);
            e = model_expect(s);
            apply_stimulus(e, $sformatf("rand%0d", c));
            model_commit(s);
            if (e.exp_write) pc = e.exp_next;
            if ($urandom_range(0, 99) == 0) begin
                do_reset($sformatf("rand rst%0d", c));
                pc = 32'h0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
